// File: rtl/cpu_pkg.sv
// Shared CPU data-side types and constants for the data-memory write buffer.
package cpu_pkg;

  localparam int unsigned WORD_W        = 64;
  localparam int unsigned OFS_W         = 3;
  localparam int unsigned DEF_ADDR_BITS = 10;

  // Default-width write-buffer entry; modules with a different ADDR_BITS
  // declare the same shape locally.
  typedef struct packed {
    logic [DEF_ADDR_BITS-1:0] idx;
    logic [WORD_W-1:0]        data;
  } wb_entry_t;

  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[OFS_W-1:0] != '0;
  endfunction

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// Posted-store FIFO: entry storage, pointers, occupancy and a
// combinational youngest-match lookup for load forwarding.
module wbuf_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [ADDR_BITS-1:0] push_idx,
  input  logic [WORD_W-1:0]    push_data,
  input  logic                 pop,
  output logic [ADDR_BITS-1:0] head_idx,
  output logic [WORD_W-1:0]    head_data,
  output logic                 full,
  output logic                 empty,
  input  logic [ADDR_BITS-1:0] look_idx,
  output logic                 hit,
  output logic [WORD_W-1:0]    hit_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic [WORD_W-1:0]    data;
  } entry_t;

  entry_t             ent [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_idx  = ent[head].idx;
  assign head_data = ent[head].data;

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_push) begin
        tail        <= tail + PTR_W'(1);
        valid[tail] <= 1'b1;
      end
      if (do_pop) begin
        head        <= head + PTR_W'(1);
        valid[head] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; contents are qualified by valid, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ent[tail] <= '{idx: push_idx, data: push_data};
    end
  end

  // Youngest-match lookup: scan oldest-to-youngest so the entry nearest
  // tail overwrites any older match.
  always_comb begin
    logic [PTR_W-1:0] pos;
    hit      = 1'b0;
    hit_data = '0;
    pos      = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      pos = tail - PTR_W'(k);
      if (valid[pos] && (ent[pos].idx == look_idx)) begin
        hit      = 1'b1;
        hit_data = ent[pos].data;
      end
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory responder: posted stores via a write buffer, single-ported
// word array, same-cycle loads with buffer forwarding.
module dmem_wbuf
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned WB_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] Addr,
  input  logic              WrEn_d,
  input  logic              RdEn_d,
  input  logic [WORD_W-1:0] Dout,
  output logic [WORD_W-1:0] Db,
  output logic              stall,
  output logic              misalign,
  output logic              wb_empty
);

  logic [ADDR_BITS-1:0] idx;
  logic                 unused_addr_hi;
  logic [ADDR_BITS-1:0] head_idx;
  logic [WORD_W-1:0]    head_data;
  logic                 full;
  logic                 empty;
  logic                 hit;
  logic [WORD_W-1:0]    hit_data;
  logic                 drain;
  logic [WORD_W-1:0]    mem [2**ADDR_BITS];

  // Upper address bits alias onto the array.
  assign idx            = Addr[ADDR_BITS+OFS_W-1:OFS_W];
  assign unused_addr_hi = ^Addr[WORD_W-1:ADDR_BITS+OFS_W];

  // Loads own the array port; the buffer drains only in load-free cycles.
  assign drain = ~RdEn_d & ~empty;

  wbuf_fifo #(
    .ADDR_BITS (ADDR_BITS),
    .DEPTH     (WB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (WrEn_d),
    .push_idx  (idx),
    .push_data (Dout),
    .pop       (~RdEn_d),
    .head_idx  (head_idx),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .look_idx  (idx),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  assign stall    = rst & WrEn_d & full;
  assign wb_empty = empty;

  // Drain the head entry into the word array.
  always_ff @(posedge clk) begin
    if (drain) begin
      mem[head_idx] <= head_data;
    end
  end

  // Load data: buffer forwarding first, then the array; zero otherwise.
  always_comb begin
    Db = '0;
    if (rst && RdEn_d && !WrEn_d) begin
      Db = hit ? hit_data : mem[idx];
    end
  end

  // One-cycle misalignment pulse for the request just presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= (WrEn_d | RdEn_d) & is_misaligned(Addr);
    end
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf with an expectation queue.
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] Addr;
  logic        WrEn_d;
  logic        RdEn_d;
  logic [63:0] Dout;
  logic [63:0] Db;
  logic        stall;
  logic        misalign;
  logic        wb_empty;

  int n_tests = 0;
  int n_fail  = 0;

  string       tag_q[$];
  logic [63:0] val_q[$];

  dmem_wbuf #(
    .ADDR_BITS (10),
    .WB_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Addr     (Addr),
    .WrEn_d   (WrEn_d),
    .RdEn_d   (RdEn_d),
    .Dout     (Dout),
    .Db       (Db),
    .stall    (stall),
    .misalign (misalign),
    .wb_empty (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic re, input logic [63:0] a, input logic [63:0] d);
    WrEn_d = we;
    RdEn_d = re;
    Addr   = a;
    Dout   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic check_v(input logic [63:0] got);
    string       t;
    logic [63:0] e;
    n_tests++;
    assert (val_q.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_underflow: observed %h expected <queued value>", got);
    end
    if (val_q.size() != 0) begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (got === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, got, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(0, 0, 64'h0, 64'h0);

    // Reset-state outputs
    #2;
    drive(0, 1, 64'h10, 64'h0);
    expect_v("rst_db", 64'h0); expect_v("rst_empty", 64'h1); expect_v("rst_misalign", 64'h0);
    #1; check_v(Db); check_v(64'(wb_empty)); check_v(64'(misalign));
    drive(1, 0, 64'h10, 64'h0);
    expect_v("rst_stall", 64'h0);
    #1; check_v(64'(stall));
    drive(0, 0, 64'h0, 64'h0);
    @(posedge clk); #3 rst = 1'b1;
    tick();

    // Preload word 2 through the buffer
    drive(1, 0, 64'h10, 64'hDEAD);
    expect_v("pre_stall", 64'h0); expect_v("pre_empty0", 64'h1);
    #1; check_v(64'(stall)); check_v(64'(wb_empty));
    tick();
    drive(0, 0, 64'h0, 64'h0);
    expect_v("pre_pending", 64'h0);
    #1; check_v(64'(wb_empty));
    tick();
    expect_v("pre_drained", 64'h1);
    #1; check_v(64'(wb_empty));

    // Array load
    drive(0, 1, 64'h10, 64'h0);
    expect_v("ld_db", 64'hDEAD); expect_v("ld_empty", 64'h1); expect_v("ld_stall", 64'h0);
    #1; check_v(Db); check_v(64'(wb_empty)); check_v(64'(stall));
    tick();

    // Forwarding, then the same word from the array
    drive(1, 0, 64'h20, 64'h1111);
    tick();
    drive(0, 1, 64'h20, 64'h0);
    expect_v("fwd_db", 64'h1111); expect_v("fwd_empty", 64'h0);
    #1; check_v(Db); check_v(64'(wb_empty));
    tick();
    drive(0, 0, 64'h0, 64'h0);
    tick();
    drive(0, 1, 64'h20, 64'h0);
    expect_v("arr_empty", 64'h1); expect_v("arr_db", 64'h1111);
    #1; check_v(64'(wb_empty)); check_v(Db);
    tick();

    // Two stores to one word; youngest wins, drain order preserved
    drive(1, 0, 64'h40, 64'hA);
    tick();
    drive(1, 1, 64'h40, 64'hB);
    expect_v("ill_db", 64'h0); expect_v("ill_stall", 64'h0);
    #1; check_v(Db); check_v(64'(stall));
    tick();
    drive(0, 1, 64'h40, 64'h0);
    expect_v("young_db", 64'hB);
    #1; check_v(Db);
    tick();
    drive(0, 0, 64'h0, 64'h0);
    tick();
    expect_v("young_pending", 64'h0);
    #1; check_v(64'(wb_empty));
    tick();
    drive(0, 1, 64'h40, 64'h0);
    expect_v("young_empty", 64'h1); expect_v("young_arr_db", 64'hB);
    #1; check_v(64'(wb_empty)); check_v(Db);
    tick();

    // Fill with drains blocked, then release
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 64'h100 + 64'(8 * i), 64'h500 + 64'(i));
      expect_v("fill_stall", 64'h0);
      #1; check_v(64'(stall));
      tick();
    end
    drive(1, 1, 64'h120, 64'h504);
    expect_v("full_stall", 64'h1); expect_v("full_empty", 64'h0);
    #1; check_v(64'(stall)); check_v(64'(wb_empty));
    tick();
    drive(1, 0, 64'h120, 64'h504);
    expect_v("held_stall", 64'h1);
    #1; check_v(64'(stall));
    tick();
    expect_v("release_stall", 64'h0);
    #1; check_v(64'(stall));
    tick();
    drive(0, 0, 64'h0, 64'h0);
    tick(); tick(); tick();
    expect_v("fill_drained", 64'h1);
    #1; check_v(64'(wb_empty));
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 64'h100 + 64'(8 * i), 64'h0);
      expect_v("fill_db", 64'h500 + 64'(i));
      #1; check_v(Db);
      tick();
    end

    // Misaligned load
    drive(0, 1, 64'h13, 64'h0);
    expect_v("mis_db", 64'hDEAD); expect_v("mis_before", 64'h0);
    #1; check_v(Db); check_v(64'(misalign));
    tick();
    drive(0, 0, 64'h0, 64'h0);
    expect_v("mis_pulse", 64'h1);
    #1; check_v(64'(misalign));
    tick();
    expect_v("mis_clear", 64'h0);
    #1; check_v(64'(misalign));

    // Misaligned store uses the truncated index
    drive(1, 0, 64'h21, 64'h2222);
    expect_v("mst_stall", 64'h0);
    #1; check_v(64'(stall));
    tick();
    drive(0, 1, 64'h20, 64'h0);
    expect_v("mst_pulse", 64'h1); expect_v("mst_db", 64'h2222);
    #1; check_v(64'(misalign)); check_v(Db);
    tick();
    drive(0, 0, 64'h0, 64'h0);
    expect_v("mst_clear", 64'h0);
    #1; check_v(64'(misalign));
    tick();
    expect_v("mst_drained", 64'h1);
    #1; check_v(64'(wb_empty));

    // Reset discards pending stores
    drive(1, 0, 64'h10, 64'hBAD1);
    tick();
    drive(1, 1, 64'h20, 64'hBAD2);
    tick();
    drive(1, 1, 64'h40, 64'hBAD3);
    tick();
    drive(0, 0, 64'h0, 64'h0);
    expect_v("lost_pending", 64'h0);
    #1; check_v(64'(wb_empty));
    #2 rst = 1'b0;
    drive(1, 0, 64'h10, 64'h0);
    expect_v("lost_empty", 64'h1); expect_v("lost_stall", 64'h0);
    #1; check_v(64'(wb_empty)); check_v(64'(stall));
    drive(0, 1, 64'h10, 64'h0);
    expect_v("lost_db_rst", 64'h0);
    #1; check_v(Db);
    drive(0, 0, 64'h0, 64'h0);
    @(posedge clk); #3 rst = 1'b1;
    tick();
    drive(0, 1, 64'h10, 64'h0);
    expect_v("lost_w2", 64'hDEAD);
    #1; check_v(Db);
    tick();
    drive(0, 1, 64'h20, 64'h0);
    expect_v("lost_w4", 64'h2222);
    #1; check_v(Db);
    tick();
    drive(0, 1, 64'h40, 64'h0);
    expect_v("lost_w8", 64'hB);
    #1; check_v(Db);
    tick();
    drive(0, 0, 64'h0, 64'h0);

    n_tests++;
    assert (val_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d expected 0", val_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
